// File: rtl/main_mem_ctrl.sv
// main_mem_ctrl: single-port 32-bit word memory behind an IDLE/WAIT/RESP handshake with fixed latency.
// Optional macro MAIN_MEM_FAST_WRITE_EN: writes complete with an effective latency of 1.
module main_mem_ctrl #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              busy,
  output logic [15:0]       txn_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic [15:0]       txn_count_q;
  logic [31:0]       mem_q [2**ADDR_W];

  logic [3:0]        lat_m1_s;
  logic              accept_s;
  logic              enter_resp_s;
  logic              op_we_s;
  logic [ADDR_W-1:0] op_addr_s;
  logic [31:0]       op_wdata_s;

`ifdef MAIN_MEM_FAST_WRITE_EN
  assign lat_m1_s = req_we ? 4'd0 : LAT_M1;
`else
  assign lat_m1_s = LAT_M1;
`endif

  assign accept_s = (state_q == IDLE) && req_valid;

  // A latency-1 transaction enters RESP on its acceptance edge, so it must use the live request.
  assign op_we_s    = (state_q == IDLE) ? req_we    : we_q;
  assign op_addr_s  = (state_q == IDLE) ? req_addr  : addr_q;
  assign op_wdata_s = (state_q == IDLE) ? req_wdata : wdata_q;

  // Next-state and latency counter logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    enter_resp_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          cnt_d = lat_m1_s;
          if (lat_m1_s == 4'd0) begin
            state_d      = RESP;
            enter_resp_s = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d      = RESP;
          enter_resp_s = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State, counter and completion counter registers.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      txn_count_q <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == RESP) begin
        txn_count_q <= txn_count_q + 16'd1;
      end
    end
  end

  // Request capture at acceptance.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
    end else if (accept_s) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Array write; contents survive reset, and aborted writes never reach this edge.
  always_ff @(posedge clk) begin
    if (enter_resp_s && op_we_s) begin
      mem_q[op_addr_s] <= op_wdata_s;
    end
  end

  // Read data is captured on RESP entry and held otherwise.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rdata_q <= 32'd0;
    end else if (enter_resp_s && !op_we_s) begin
      rdata_q <= mem_q[op_addr_s];
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign txn_count  = txn_count_q;

endmodule

// File: tb/tb_main_mem_ctrl.sv
// Directed bench for main_mem_ctrl: transaction-level reference model checked every cycle,
// plus hand-computed expectations for latency, data, throughput, reset abort and counter wrap.
module tb_main_mem_ctrl;

  localparam int LAT = 4;
`ifdef MAIN_MEM_FAST_WRITE_EN
  localparam int WLAT = 1;
`else
  localparam int WLAT = LAT;
`endif

  logic        clk       = 1'b0;
  logic        rst_b     = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we    = 1'b0;
  logic [9:0]  req_addr  = 10'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        busy;
  logic [15:0] txn_count;

  main_mem_ctrl #(.ADDR_W(10), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .busy       (busy),
    .txn_count  (txn_count)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en        = 1'b0;
  bit force_pending = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a transaction accepted on edge n completes on edge n+lat-1
  // and the controller is free again after edge n+lat.
  logic [31:0] mem_m [1024];
  bit          m_busy  = 1'b0;
  bit          m_resp  = 1'b0;
  int          due_m   = 0;
  int          edge_n  = 0;
  int          m_acc   = 0;
  logic        m_we    = 1'b0;
  logic [9:0]  m_addr  = 10'd0;
  logic [31:0] m_wdata = 32'd0;
  logic [31:0] m_rdata = 32'd0;
  logic [15:0] m_cnt   = 16'd0;

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      m_busy  = 1'b0;
      m_resp  = 1'b0;
      m_rdata = 32'd0;
      m_cnt   = 16'd0;
    end else begin
      edge_n++;
      if (force_pending) m_cnt = 16'hFFFF;
      if (m_resp) begin
        m_resp = 1'b0;
        m_busy = 1'b0;
        m_cnt  = m_cnt + 16'd1;
      end else if (!m_busy && req_valid) begin
        m_busy  = 1'b1;
        m_acc++;
        m_we    = req_we;
        m_addr  = req_addr;
        m_wdata = req_wdata;
        due_m   = edge_n + (req_we ? WLAT : LAT) - 1;
      end
      if (m_busy && !m_resp && edge_n == due_m) begin
        m_resp = 1'b1;
        if (m_we) mem_m[m_addr] = m_wdata;
        else      m_rdata = mem_m[m_addr];
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("req_ready",  32'(req_ready),  32'(!m_busy));
      check("busy",       32'(busy),       32'(m_busy));
      check("resp_valid", 32'(resp_valid), 32'(m_resp));
      check("txn_count",  32'(txn_count),  32'(m_cnt));
      check("resp_rdata", resp_rdata,      m_rdata);
    end
  end

  // Issue one request from an idle controller; lat counts edges from acceptance (inclusive) to RESP entry.
  task automatic do_txn(input logic we, input logic [9:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] rd);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!resp_valid) check("resp_timeout", 32'(resp_valid), 32'd1);
    rd = resp_rdata;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          lat;
    int          acc0;
    int          dacc;
    logic [31:0] rd;
    logic [31:0] exp_a0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready",  32'(req_ready),  32'd1);
    check("rst_busy",   32'(busy),       32'd0);
    check("rst_resp",   32'(resp_valid), 32'd0);
    check("rst_rdata",  resp_rdata,      32'd0);
    check("rst_txn",    32'(txn_count),  32'd0);
    rst_b  = 1'b1;
    chk_en = 1'b1;
    @(posedge clk);
    #1;

    do_txn(1'b1, 10'h005, 32'hDEADBEEF, lat, rd);
    check("wr005_lat", 32'(lat), 32'(WLAT));
    check("wr005_txn", 32'(txn_count), 32'd1);

    do_txn(1'b0, 10'h005, 32'd0, lat, rd);
    check("rd005_lat",  32'(lat), 32'd4);
    check("rd005_data", rd, 32'hDEADBEEF);
    check("rd005_txn",  32'(txn_count), 32'd2);

    do_txn(1'b1, 10'h3FF, 32'hCAFE03FF, lat, rd);
    check("wr3ff_lat",   32'(lat), 32'(WLAT));
    check("wr3ff_rdata", rd, 32'hDEADBEEF);

    do_txn(1'b0, 10'h3FF, 32'd0, lat, rd);
    check("rd3ff_lat",  32'(lat), 32'd4);
    check("rd3ff_data", rd, 32'hCAFE03FF);

    // Back-to-back pressure: 30 edges with req_valid held, writes alternating 0x010/0x011.
    acc0 = m_acc;
    dacc = 0;
    for (int i = 0; i < 30; i++) begin
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = (i % 2 == 0) ? 10'h010 : 10'h011;
      req_wdata = 32'hA5A50000 | 32'(i);
      if (req_ready) dacc++;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    check("hold_acc_model", 32'(m_acc - acc0), 32'(30 / (WLAT + 1)));
    check("hold_acc_dut",   32'(dacc),         32'(30 / (WLAT + 1)));
    check("hold_txn",       32'(txn_count),    32'(4 + 30 / (WLAT + 1)));

`ifndef MAIN_MEM_FAST_WRITE_EN
    do_txn(1'b0, 10'h010, 32'd0, lat, rd);
    check("rd010_data", rd, 32'hA5A50014);
`endif

    // Reset during WAIT aborts a pending write.
    do_txn(1'b1, 10'h0A0, 32'h000000A0, lat, rd);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 10'h0A0;
    req_wdata = 32'h12345678;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_b = 1'b0;
    #1;
    check("abort_ready", 32'(req_ready),  32'd1);
    check("abort_busy",  32'(busy),       32'd0);
    check("abort_resp",  32'(resp_valid), 32'd0);
    check("abort_txn",   32'(txn_count),  32'd0);
    check("abort_rdata", resp_rdata,      32'd0);
    @(posedge clk);
    #1 rst_b = 1'b1;
    @(posedge clk);
    #1;
`ifdef MAIN_MEM_FAST_WRITE_EN
    exp_a0 = 32'h12345678;
`else
    exp_a0 = 32'h000000A0;
`endif
    do_txn(1'b0, 10'h0A0, 32'd0, lat, rd);
    check("rd0a0_data", rd, exp_a0);
    check("rd0a0_txn",  32'(txn_count), 32'd1);

    // Counter wrap from 16'hFFFF.
    chk_en        = 1'b0;
    force dut.txn_count_q = 16'hFFFF;
    force_pending = 1'b1;
    @(posedge clk);
    #1 force_pending = 1'b0;
    release dut.txn_count_q;
    #1;
    check("wrap_pre", 32'(txn_count), 32'h0000FFFF);
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    do_txn(1'b0, 10'h005, 32'd0, lat, rd);
    check("wrap_data", rd, 32'hDEADBEEF);
    check("wrap_txn",  32'(txn_count), 32'd0);

    @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/main_mem_ctrl.md
MAIN_MEM_CTRL -- requirements
Module: main_mem_ctrl

Interface
REQ-001 Parameter ADDR_W, 10, word-address width; array depth is 2**ADDR_W 32-bit words.
REQ-002 Parameter LATENCY, 4, rising edges from request acceptance to response; legal range 1..15.
REQ-003 Port clk  input  1  clock; all state updates on the rising edge.
REQ-004 Port rst_b  input  1  reset, asynchronous, active-low.
REQ-005 Port req_valid  input  1  request present from the cache control unit.
REQ-006 Port req_ready  output  1  controller can accept a request this cycle.
REQ-007 Port req_we  input  1  1 = write (dirty-block write-back), 0 = read (refill).
REQ-008 Port req_addr  input  ADDR_W  word address.
REQ-009 Port req_wdata  input  32  write data.
REQ-010 Port resp_valid  output  1  one-cycle completion pulse.
REQ-011 Port resp_rdata  output  32  read data; valid only while resp_valid=1 for a read.
REQ-012 Port busy  output  1  transaction in flight; equals ~req_ready.
REQ-013 Port txn_count  output  16  number of completed transactions.

Function
REQ-014 FSM states shall be IDLE, WAIT, RESP.
REQ-015 req_ready shall be 1 only in IDLE.
REQ-016 A request is accepted at a rising edge where req_valid=1 and req_ready=1; req_we, req_addr and req_wdata are latched at that edge, and the FSM moves IDLE->WAIT with the latency counter loaded to LATENCY-1.
REQ-017 In WAIT the counter decrements once per edge; the edge on which it is 0 moves WAIT->RESP.
REQ-018 LATENCY=1 shall go IDLE->RESP directly at the acceptance edge.
REQ-019 resp_valid shall be 1 exactly while in RESP, which is the cycle following the LATENCY-th edge after acceptance; RESP->IDLE always follows after one cycle.
REQ-020 A write shall update mem[addr] at the edge entering RESP; a read shall load resp_rdata from mem[addr] at that same edge.
REQ-021 resp_rdata shall hold its last value outside RESP; write responses leave resp_rdata unchanged.
REQ-022 Request inputs while req_ready=0 shall be ignored, so no second request is accepted in WAIT or RESP.
REQ-023 A read of an address written by the immediately preceding transaction shall return the new data.
REQ-024 txn_count shall increment by 1 at every edge leaving RESP and wrap from 16'hFFFF to 0.

Reset
REQ-025 rst_b=0 shall immediately force state IDLE, counter 0, resp_valid 0, resp_rdata 0 and txn_count 0, making req_ready=1 and busy=0.
REQ-026 Reset in WAIT or RESP shall abort the transaction: a pending write shall not modify the array and no resp_valid pulse shall occur.
REQ-027 Array contents shall not be cleared by reset.

Configuration
REQ-028 Macro MAIN_MEM_FAST_WRITE_EN: when defined, writes shall use an effective latency of 1 (resp_valid in the cycle after acceptance) and reads keep LATENCY; when undefined, all transactions use LATENCY.

Verification
REQ-029 Reset, then write addr 0x005 data 0xDEADBEEF, LATENCY=4 -> resp_valid pulses in the cycle after the 4th edge after acceptance; txn_count=1.
REQ-030 Read addr 0x005 after the write in REQ-029 -> resp_rdata=0xDEADBEEF with resp_valid, in the cycle after the 4th edge after acceptance.
REQ-031 Hold req_valid=1 continuously with alternating addresses -> exactly one acceptance per LATENCY+1 cycles, no acceptance while busy=1.
REQ-032 Write 0x12345678 to 0x0A0, assert rst_b=0 at edge 2 of WAIT, then read 0x0A0 -> no resp_valid before reset, old contents returned, txn_count=1 after the read.
REQ-033 Preload txn_count near wrap by forcing 16'hFFFF, complete one read -> txn_count=0.
REQ-034 Build with MAIN_MEM_FAST_WRITE_EN, write addr 0x3FF -> resp_valid in the cycle after acceptance; a read of 0x3FF still takes LATENCY edges.
